reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_arb_pkg.sv | 13 +
 rtl/dff.sv | 12 +
 rtl/rr_pick.sv | 32 +++
 rtl/reg_write_arbiter.sv | 120 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and default sizing for the register write arbiter.
package reg_arb_pkg;

    localparam int REG_ARB_NREQ  = 4;
    localparam int REG_ARB_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        COMMIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dff.sv
// Single-bit D flip-flop cell used to build registered datapath bits.
module dff (
    input  logic clk,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        q <= d;
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic            valid,
    output logic [IDXW-1:0] idx
);

    localparam logic [IDXW:0] NREQ_W = (IDXW+1)'(NREQ);

    logic [IDXW:0]   sum;
    logic [IDXW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum  = {1'b0, ptr} + (IDXW+1)'(k);
            cand = IDXW'((sum >= NREQ_W) ? (sum - NREQ_W) : sum);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting NREQ requesters write access to one shared register.
// Optional grant locking is enabled by defining REG_ARB_LOCK_EN.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ  = REG_ARB_NREQ,
    parameter int WIDTH = REG_ARB_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    input  logic [NREQ-1:0]       lock,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      q,
    output logic                  busy
);

    localparam int              IDXW = $clog2(NREQ);
    localparam logic [IDXW-1:0] LAST = IDXW'(NREQ - 1);

    arb_state_t      state;
    logic [IDXW-1:0] rr_ptr;
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] pick_idx;
    logic            pick_valid;
    logic            load;
    logic            keep;
    logic [WIDTH-1:0] wsel;
    logic [WIDTH-1:0] q_d;

    function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
        return (i == LAST) ? '0 : i + IDXW'(1);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] i);
        return NREQ'(1) << i;
    endfunction

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef REG_ARB_LOCK_EN
    assign keep = lock[idx] && req[idx];
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign keep        = 1'b0;
`endif

    // Register load: reset clears, a still-requesting grantee writes, otherwise hold.
    assign wsel = wdata[idx*WIDTH +: WIDTH];
    assign load = (state == GRANT) && req[idx];
    assign q_d  = rst ? '0 : (load ? wsel : q);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_q
        dff u_dff (
            .clk (clk),
            .d   (q_d[gi]),
            .q   (q[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            idx    <= '0;
            gnt    <= '0;
            ack    <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        idx   <= pick_idx;
                        gnt   <= onehot(pick_idx);
                        busy  <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    gnt <= '0;
                    if (req[idx]) begin
                        ack   <= onehot(idx);
                        state <= COMMIT;
                    end else begin
                        rr_ptr <= next_idx(idx);
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                COMMIT: begin
                    ack <= '0;
                    // A locked grantee re-enters GRANT without moving the pointer.
                    if (keep) begin
                        gnt   <= onehot(idx);
                        state <= GRANT;
                    end else begin
                        rr_ptr <= next_idx(idx);
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus randomized traffic vs a transaction model.
module tb_reg_write_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       lock;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wdata (wdata),
        .lock  (lock),
        .gnt   (gnt),
        .ack   (ack),
        .q     (q),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req  = '0;
        lock = '0;
        rst  = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        req   = '0;
        lock  = '0;
        wdata = '0;
        step();
        step();
        checks++; if (q !== 8'h00)  begin errors++; $display("FAIL reset_q got=%h exp=00", q); end
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        req = 4'b0001;
        wdata[0 +: 8] = 8'hA5;
        step();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
        checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
        step();
        checks++; if (q !== 8'hA5)     begin errors++; $display("FAIL single_q got=%h exp=a5", q); end
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack got=%b exp=0001", ack); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_commit got=%b exp=0000", gnt); end
        req = '0;
        step();
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_end got=%b exp=0000", ack); end
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [NREQ-1:0] eg;
        logic [WIDTH-1:0] eq;
        apply_reset();
        for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = 8'(8'h10 + i);
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            eg = 4'(1) << exp_order[t];
            eq = 8'(8'h10 + exp_order[t]);
            step();
            checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", t, gnt, eg); end
            step();
            checks++; if (q !== eq) begin errors++; $display("FAIL rr_q[%0d] got=%h exp=%h", t, q, eq); end
            checks++; if (ack !== eg) begin errors++; $display("FAIL rr_ack[%0d] got=%b exp=%b", t, ack, eg); end
            step();
        end
        req = '0;
        step();
    endtask

    task automatic test_withdraw();
        apply_reset();
        req = 4'b0001;
        wdata[0 +: 8] = 8'h3C;
        step();
        step();
        req = '0;
        step();
        req = 4'b0100;
        wdata[2*8 +: 8] = 8'h77;
        step();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wd_gnt got=%b exp=0100", gnt); end
        req = 4'b1001;
        wdata[3*8 +: 8] = 8'h99;
        wdata[0 +: 8]   = 8'h11;
        step();
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL wd_ack got=%b exp=0000", ack); end
        checks++; if (q !== 8'h3C)     begin errors++; $display("FAIL wd_q got=%h exp=3c", q); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL wd_busy got=%b exp=0", busy); end
        step();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wd_next_gnt got=%b exp=1000", gnt); end
        step();
        checks++; if (q !== 8'h99)     begin errors++; $display("FAIL wd_next_q got=%h exp=99", q); end
        req = '0;
        step();
    endtask

    task automatic test_reset_in_grant();
        apply_reset();
        req = 4'b0010;
        wdata[1*8 +: 8] = 8'h5A;
        step();
        step();
        req = '0;
        step();
        req = 4'b0001;
        wdata[0 +: 8] = 8'hFF;
        step();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rg_gnt got=%b exp=0001", gnt); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (q !== 8'h00)     begin errors++; $display("FAIL rg_q got=%h exp=00", q); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rg_ack got=%b exp=0000", ack); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rg_gnt_clr got=%b exp=0000", gnt); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rg_busy got=%b exp=0", busy); end
        req = 4'b0110;
        wdata[1*8 +: 8] = 8'h21;
        wdata[2*8 +: 8] = 8'h32;
        step();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rg_ptr_gnt got=%b exp=0010", gnt); end
        step();
        checks++; if (q !== 8'h21)     begin errors++; $display("FAIL rg_after_q got=%h exp=21", q); end
        req = '0;
        step();
    endtask

    task automatic test_lock();
        int exp_c[$];
        int exp_i[$];
        int got_c[$];
        int got_i[$];
        int cnt0 = 0;
`ifdef REG_ARB_LOCK_EN
        exp_c = '{2, 4, 6, 9, 12};
        exp_i = '{0, 0, 0, 1, 0};
`else
        exp_c = '{2, 5, 8, 11};
        exp_i = '{0, 1, 0, 1};
`endif
        apply_reset();
        wdata[0 +: 8] = 8'hA0;
        wdata[8 +: 8] = 8'hB1;
        req  = 4'b0011;
        lock = 4'b0001;
        for (int c = 1; c <= 12; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    got_c.push_back(c);
                    got_i.push_back(i);
                    if (i == 0) cnt0++;
                end
            end
            if (cnt0 >= 3) lock = '0;
        end
        checks++;
        if (got_c.size() !== exp_c.size()) begin
            errors++; $display("FAIL lock_ack_count got=%0d exp=%0d", got_c.size(), exp_c.size());
        end
        for (int k = 0; k < exp_c.size() && k < got_c.size(); k++) begin
            checks++;
            if (got_c[k] !== exp_c[k] || got_i[k] !== exp_i[k]) begin
                errors++;
                $display("FAIL lock_ack[%0d] got=req%0d@%0d exp=req%0d@%0d", k, got_i[k], got_c[k], exp_i[k], exp_c[k]);
            end
        end
        req  = '0;
        lock = '0;
        step();
        step();
    endtask

    task automatic test_random();
        int m_ptr = 0;
        int arb_edge = -10;
        int free_edge = 0;
        int w = 0;
        logic [WIDTH-1:0] m_q = '0;
        logic [WIDTH-1:0] w_q = '0;
        logic [NREQ-1:0] eg, ea;
        logic eb;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    wdata[i*WIDTH +: WIDTH] = 8'($urandom);
                end
            end
`ifndef REG_ARB_LOCK_EN
            lock = 4'($urandom);
`endif
            eg = '0;
            ea = '0;
            eb = 1'b0;
            if (c == arb_edge + 1) begin
                ea    = 4'(1) << w;
                eb    = 1'b1;
                m_q   = w_q;
                m_ptr = (w + 1) % NREQ;
            end else if (c >= free_edge && req != '0) begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    if (req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                end
                arb_edge  = c;
                free_edge = c + 3;
                w_q       = wdata[w*WIDTH +: WIDTH];
                eg        = 4'(1) << w;
                eb        = 1'b1;
            end
            step();
            checks++; if (gnt !== eg)  begin errors++; $display("FAIL rand_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
            checks++; if (ack !== ea)  begin errors++; $display("FAIL rand_ack c=%0d got=%b exp=%b", c, ack, ea); end
            checks++; if (busy !== eb) begin errors++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, busy, eb); end
            checks++; if (q !== m_q)   begin errors++; $display("FAIL rand_q c=%0d got=%h exp=%h", c, q, m_q); end
            req = req & ~ack;
        end
        req  = '0;
        lock = '0;
        step();
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        lock  = '0;
        wdata = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_withdraw();
        test_reset_in_grant();
        test_lock();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
